// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: reset vector, instruction size, branch
// target arithmetic and the prefetch entry layout.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int          INST_BYTES       = 4;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // PC-relative branch target: the word after the branch plus a signed word
    // offset. Computed at 64 bits so any narrower caller simply truncates and
    // gets the correct modulo-2^ADDR_W result. Low two bits of pc are ignored.
    function automatic logic [63:0] br_target(input logic [63:0] pc,
                                              input logic [15:0] imm16);
        logic [63:0] base;
        logic [63:0] offset;
        base   = {pc[63:2], 2'b00};
        offset = {{46{imm16[15]}}, imm16, 2'b00};
        return base + 64'(INST_BYTES) + offset;
    endfunction

endpackage

// File: rtl/pf_fifo.sv
// Prefetch FIFO: DEPTH-entry synchronous FIFO with first-word fall-through
// head, single-cycle flush and an occupancy count used for fetch credits.
module pf_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents only become visible once counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit_pf.sv
// Instruction fetch unit with prefetch buffer: owns the PC, issues one word
// fetch per cycle to a 1-cycle-latency memory while credits allow, buffers
// responses and hands them to decode over valid/ready. A taken branch
// redirects the PC and flushes all younger work.
module fetch_unit_pf
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_imm16,
    input  logic              halt,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = ADDR_W'(RESET_PC) & ~ADDR_W'(3);

    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        resp_pc;
    logic [ADDR_W-1:0]        target;
    logic                     inflight;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic [OCC_W-1:0]         occupancy;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [INST_W+ADDR_W-1:0] fifo_head;

    assign target = ADDR_W'(br_target(64'(br_pc), br_imm16));

    // Credits: buffered entries plus the outstanding response, less the entry
    // leaving this cycle, must leave room for the request being issued.
    assign pop       = !fifo_empty && inst_ready;
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = rst_n && !halt && !br_taken && (occupancy < OCC_W'(DEPTH));

    assign imem_en   = issue;
    assign imem_addr = pc;

    // A redirect in the response cycle kills the response; the full guard is
    // unreachable while the credit rule holds.
    assign push = inflight && !br_taken && !fifo_full;

    assign inst_valid       = !fifo_empty;
    assign {inst, inst_pc}  = fifo_empty ? '0 : fifo_head;

    // PC sequencing and the single outstanding-request flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC_ALIGNED;
            inflight <= 1'b0;
        end else if (br_taken) begin
            pc       <= target;
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + ADDR_W'(INST_BYTES);
            inflight <= 1'b1;
        end else begin
            inflight <= 1'b0;
        end
    end

    // Remember the address of the outstanding request to tag its response.
    always_ff @(posedge clk) begin
        if (issue) resp_pc <= pc;
    end

    pf_fifo #(
        .WIDTH (INST_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_rdata, resp_pc}),
        .pop       (pop),
        .flush     (br_taken),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

endmodule
